// File: rtl/alt_vipvfr131_vfr_bank_scheduler_if.sv
// Producer post / buffer release / frame-reader control-slave bundle for the bank scheduler.
// master = scheduler side, slave = producer plus frame-reader side.
interface alt_vipvfr131_vfr_bank_scheduler_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_base;
    logic [15:0] in_width;
    logic [15:0] in_height;
    logic [3:0]  in_interlaced;
    logic        rel_valid;
    logic [31:0] rel_base;
    logic [4:0]  av_address;
    logic        av_write;
    logic [31:0] av_writedata;
    logic        av_waitrequest;
    logic        av_irq;

    modport master (
        input  in_valid, in_base, in_width, in_height, in_interlaced,
        output in_ready,
        output rel_valid, rel_base,
        output av_address, av_write, av_writedata,
        input  av_waitrequest, av_irq
    );

    modport slave (
        output in_valid, in_base, in_width, in_height, in_interlaced,
        input  in_ready,
        input  rel_valid, rel_base,
        input  av_address, av_write, av_writedata,
        output av_waitrequest, av_irq
    );
endinterface

// File: rtl/alt_vipvfr131_vfr_bank_scheduler.sv
// Programs the idle frame-reader bank from a one-deep post slot, flips next_bank, acks irqs and releases old buffers.
// Latency: accepted post to first register write 34 cycles (33-cycle divide), then back-to-back writes.
// Backpressure: writes hold on av_waitrequest; posts refused while the slot is full. ALT_VFR_SCHED_STATS_EN adds frame counters.
module alt_vipvfr131_vfr_bank_scheduler #(
    parameter int BPS             = 8,
    parameter int CHANNELS_IN_PAR = 3,
    parameter int MEM_PORT_WIDTH  = 256
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    alt_vipvfr131_vfr_bank_scheduler_if.master bus,
    output logic running
`ifdef ALT_VFR_SCHED_STATS_EN
    ,
    output logic [31:0] frames_shown,
    output logic [31:0] frames_repeated
`endif
);
    localparam int          PPW_DIV     = MEM_PORT_WIDTH / (BPS * CHANNELS_IN_PAR);
    localparam int          PPW         = (PPW_DIV < 1) ? 1 : PPW_DIV;
    localparam logic [32:0] PPW_W       = 33'(PPW);
    localparam logic [4:0]  A_CONTROL   = 5'd0;
    localparam logic [4:0]  A_INTERRUPT = 5'd2;
    localparam logic [4:0]  A_NEXT_BANK = 5'd3;
    localparam logic [4:0]  A_BANK0     = 5'd4;
    localparam logic [4:0]  BANK_STRIDE = 5'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_PROG, S_SWITCH, S_WAIT_IRQ, S_ACK, S_GUARD
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [5:0]  cnt_q, cnt_d;

    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_base_q, pend_base_d;
    logic [15:0] pend_width_q, pend_width_d;
    logic [15:0] pend_height_q, pend_height_d;
    logic [3:0]  pend_il_q, pend_il_d;

    logic [31:0] samples_q, samples_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [32:0] trial;
    logic [31:0] words;

    logic        cur_bank_q, cur_bank_d;
    logic        shown_vld_q, shown_vld_d;
    logic [31:0] shown_base_q, shown_base_d;
    logic        old_vld_q, old_vld_d;
    logic [31:0] old_base_q, old_base_d;
    logic        running_q, running_d;
    logic        rel_valid_q, rel_valid_d;
    logic [31:0] rel_base_q, rel_base_d;

    logic        av_write_q, av_write_d;
    logic [4:0]  av_address_q, av_address_d;
    logic [31:0] av_writedata_q, av_writedata_d;

    logic        nxt_wr;
    logic [4:0]  nxt_addr;
    logic [4:0]  nxt_off;
    logic [31:0] nxt_data;
    logic        nxt_bank;

    logic        wr_done;
    logic        switch_fin;
    logic        ack_fin;
    logic        accept;

    assign wr_done    = av_write_q && !bus.av_waitrequest;
    assign switch_fin = (state_q == S_SWITCH) && wr_done && (running_q || (step_q != 3'd0));
    assign ack_fin    = (state_q == S_ACK) && wr_done;
    assign nxt_bank   = ~cur_bank_q;
    assign words      = quo_q + {31'd0, |rem_q};

    assign bus.in_ready     = !pend_vld_q && enable && !reset;
    assign accept           = bus.in_valid && bus.in_ready;
    assign bus.rel_valid    = rel_valid_q;
    assign bus.rel_base     = rel_base_q;
    assign bus.av_write     = av_write_q;
    assign bus.av_address   = av_address_q;
    assign bus.av_writedata = av_writedata_q;
    assign running          = running_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            step_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            S_IDLE: begin
                if (bus.av_irq) begin
                    state_d = S_ACK;
                    step_d  = 3'd0;
                end else if (pend_vld_q) begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == 6'd32) begin
                    state_d = S_PROG;
                    step_d  = 3'd0;
                end
            end
            S_PROG: begin
                if (wr_done) begin
                    if (step_q == 3'd5) begin
                        state_d = S_SWITCH;
                        step_d  = 3'd0;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            S_SWITCH: begin
                if (wr_done) begin
                    if (switch_fin) begin
                        state_d = S_WAIT_IRQ;
                        step_d  = 3'd0;
                    end else begin
                        step_d = 3'd1;
                    end
                end
            end
            S_WAIT_IRQ: begin
                if (bus.av_irq) begin
                    state_d = S_ACK;
                    step_d  = 3'd0;
                end
            end
            S_ACK: begin
                if (wr_done) state_d = S_GUARD;
            end
            S_GUARD: begin
                state_d = pend_vld_q ? S_CALC : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                step_d  = 3'd0;
            end
        endcase
    end

    // Register write selected by where the FSM will be next cycle, so writes chain without gaps.
    always_comb begin
        nxt_wr   = 1'b0;
        nxt_off  = 5'd0;
        nxt_addr = 5'd0;
        nxt_data = 32'd0;
        case (state_d)
            S_PROG: begin
                nxt_wr = 1'b1;
                case (step_d)
                    3'd0:    begin nxt_off = 5'd0; nxt_data = pend_base_q; end
                    3'd1:    begin nxt_off = 5'd1; nxt_data = words; end
                    3'd2:    begin nxt_off = 5'd2; nxt_data = samples_q; end
                    3'd3:    begin nxt_off = 5'd4; nxt_data = {16'd0, pend_width_q}; end
                    3'd4:    begin nxt_off = 5'd5; nxt_data = {16'd0, pend_height_q}; end
                    default: begin nxt_off = 5'd6; nxt_data = {28'd0, pend_il_q}; end
                endcase
                nxt_addr = A_BANK0 + nxt_off + (nxt_bank ? BANK_STRIDE : 5'd0);
            end
            S_SWITCH: begin
                nxt_wr = 1'b1;
                if (step_d == 3'd0) begin
                    nxt_addr = A_NEXT_BANK;
                    nxt_data = {31'd0, nxt_bank};
                end else begin
                    nxt_addr = A_CONTROL;
                    nxt_data = 32'h3;
                end
            end
            S_ACK: begin
                nxt_wr   = 1'b1;
                nxt_addr = A_INTERRUPT;
                nxt_data = 32'h1;
            end
            default: ;
        endcase
    end

    always_comb begin
        pend_vld_d    = pend_vld_q;
        pend_base_d   = pend_base_q;
        pend_width_d  = pend_width_q;
        pend_height_d = pend_height_q;
        pend_il_d     = pend_il_q;
        if (accept) begin
            pend_vld_d    = 1'b1;
            pend_base_d   = bus.in_base;
            pend_width_d  = bus.in_width;
            pend_height_d = bus.in_height;
            pend_il_d     = bus.in_interlaced;
        end
        if (switch_fin) pend_vld_d = 1'b0;

        // First CALC cycle forms the product, the remaining 32 run one restoring step each.
        cnt_d     = 6'd0;
        samples_d = samples_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        trial     = {rem_q, quo_q[31]};
        if (state_q == S_CALC) begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd0) begin
                samples_d = 32'(pend_width_q) * 32'(pend_height_q);
                quo_d     = 32'(pend_width_q) * 32'(pend_height_q);
                rem_d     = 32'd0;
            end else if (trial >= PPW_W) begin
                rem_d = 32'(trial - PPW_W);
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = trial[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
        end

        running_d    = running_q;
        cur_bank_d   = cur_bank_q;
        shown_vld_d  = shown_vld_q;
        shown_base_d = shown_base_q;
        old_vld_d    = old_vld_q;
        old_base_d   = old_base_q;
        if ((state_q == S_SWITCH) && wr_done && (step_q == 3'd1)) running_d = 1'b1;
        if (switch_fin) begin
            cur_bank_d   = nxt_bank;
            shown_vld_d  = 1'b1;
            shown_base_d = pend_base_q;
            old_vld_d    = running_q && shown_vld_q;
            old_base_d   = shown_base_q;
        end

        rel_valid_d = 1'b0;
        rel_base_d  = rel_base_q;
        if (ack_fin) begin
            old_vld_d = 1'b0;
            if (old_vld_q) begin
                rel_valid_d = 1'b1;
                rel_base_d  = old_base_q;
            end
        end

        av_write_d     = av_write_q;
        av_address_d   = av_address_q;
        av_writedata_d = av_writedata_q;
        if (!(av_write_q && bus.av_waitrequest)) begin
            av_write_d     = nxt_wr;
            av_address_d   = nxt_addr;
            av_writedata_d = nxt_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q          <= 6'd0;
            pend_vld_q     <= 1'b0;
            pend_base_q    <= 32'd0;
            pend_width_q   <= 16'd0;
            pend_height_q  <= 16'd0;
            pend_il_q      <= 4'd0;
            samples_q      <= 32'd0;
            quo_q          <= 32'd0;
            rem_q          <= 32'd0;
            cur_bank_q     <= 1'b1;
            shown_vld_q    <= 1'b0;
            shown_base_q   <= 32'd0;
            old_vld_q      <= 1'b0;
            old_base_q     <= 32'd0;
            running_q      <= 1'b0;
            rel_valid_q    <= 1'b0;
            rel_base_q     <= 32'd0;
            av_write_q     <= 1'b0;
            av_address_q   <= 5'd0;
            av_writedata_q <= 32'd0;
        end else begin
            cnt_q          <= cnt_d;
            pend_vld_q     <= pend_vld_d;
            pend_base_q    <= pend_base_d;
            pend_width_q   <= pend_width_d;
            pend_height_q  <= pend_height_d;
            pend_il_q      <= pend_il_d;
            samples_q      <= samples_d;
            quo_q          <= quo_d;
            rem_q          <= rem_d;
            cur_bank_q     <= cur_bank_d;
            shown_vld_q    <= shown_vld_d;
            shown_base_q   <= shown_base_d;
            old_vld_q      <= old_vld_d;
            old_base_q     <= old_base_d;
            running_q      <= running_d;
            rel_valid_q    <= rel_valid_d;
            rel_base_q     <= rel_base_d;
            av_write_q     <= av_write_d;
            av_address_q   <= av_address_d;
            av_writedata_q <= av_writedata_d;
        end
    end

`ifdef ALT_VFR_SCHED_STATS_EN
    logic [31:0] shown_cnt_q, shown_cnt_d;
    logic [31:0] rep_cnt_q, rep_cnt_d;

    always_comb begin
        shown_cnt_d = shown_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        if (switch_fin) shown_cnt_d = shown_cnt_q + 32'd1;
        if (ack_fin && !old_vld_q) rep_cnt_d = rep_cnt_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shown_cnt_q <= 32'd0;
            rep_cnt_q   <= 32'd0;
        end else begin
            shown_cnt_q <= shown_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
        end
    end

    assign frames_shown    = shown_cnt_q;
    assign frames_repeated = rep_cnt_q;
`endif
endmodule

// File: tb/tb_alt_vipvfr131_vfr_bank_scheduler.sv
// Directed bench for the bank scheduler: models the reader's slave as a write log with optional stalls.
module tb_alt_vipvfr131_vfr_bank_scheduler;
    logic clock = 1'b0;
    logic reset;
    logic enable;
    logic running;
`ifdef ALT_VFR_SCHED_STATS_EN
    logic [31:0] frames_shown;
    logic [31:0] frames_repeated;
`endif
    int n_checks = 0;
    int n_fail   = 0;

    alt_vipvfr131_vfr_bank_scheduler_if bus ();

    alt_vipvfr131_vfr_bank_scheduler dut (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .bus     (bus),
        .running (running)
`ifdef ALT_VFR_SCHED_STATS_EN
        ,
        .frames_shown    (frames_shown),
        .frames_repeated (frames_repeated)
`endif
    );

    always #5 clock = ~clock;

    logic [4:0]  log_a[$];
    logic [31:0] log_d[$];
    int          rel_cnt    = 0;
    logic [31:0] rel_last   = 32'd0;
    int          stall_left = 0;
    int          stall_seen = 0;
    int          stall_bad  = 0;

    // Slave model: stalls the width write (addr 8) while armed, logs completed writes and release pulses.
    always @(negedge clock) begin
        if (stall_left > 0 && bus.av_write && bus.av_address == 5'd8) begin
            stall_seen++;
            if (bus.av_writedata != 32'd100) stall_bad++;
            stall_left--;
            bus.av_waitrequest = 1'b1;
        end else begin
            bus.av_waitrequest = 1'b0;
        end
        if (bus.av_write && !bus.av_waitrequest) begin
            log_a.push_back(bus.av_address);
            log_d.push_back(bus.av_writedata);
        end
        if (bus.rel_valid) begin
            rel_cnt++;
            rel_last = bus.rel_base;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
    endtask

    task automatic post(input logic [31:0] b, input logic [15:0] w, input logic [15:0] h, input logic [3:0] il);
        int t = 0;
        bus.in_valid      = 1'b1;
        bus.in_base       = b;
        bus.in_width      = w;
        bus.in_height     = h;
        bus.in_interlaced = il;
        while (!bus.in_ready && t < 300) begin
            tick();
            t++;
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_accept: in_ready=%b, required 1 within 300 cycles", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget);
        int t = 0;
        while (log_a.size() < n && t < budget) begin
            tick();
            t++;
        end
        n_checks++;
        if (log_a.size() < n) begin
            n_fail++;
            $display("FAIL wait_writes: got %0d writes, required %0d", log_a.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1;
        bus.in_valid = 1'b0; bus.in_base = '0; bus.in_width = '0; bus.in_height = '0; bus.in_interlaced = '0;
        bus.av_irq = 1'b0; bus.av_waitrequest = 1'b0;
        repeat (3) tick();
        n_checks += 7;
        if (bus.in_ready !== 1'b0)         begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        if (bus.av_write !== 1'b0)         begin n_fail++; $display("FAIL rst_av_write: got %b want 0", bus.av_write); end
        if (bus.av_address !== 5'd0)       begin n_fail++; $display("FAIL rst_av_address: got %0d want 0", bus.av_address); end
        if (bus.av_writedata !== 32'd0)    begin n_fail++; $display("FAIL rst_av_writedata: got %0h want 0", bus.av_writedata); end
        if (running !== 1'b0)              begin n_fail++; $display("FAIL rst_running: got %b want 0", running); end
        if (bus.rel_valid !== 1'b0)        begin n_fail++; $display("FAIL rst_rel_valid: got %b want 0", bus.rel_valid); end
        if (bus.rel_base !== 32'd0)        begin n_fail++; $display("FAIL rst_rel_base: got %0h want 0", bus.rel_base); end
        reset = 1'b0;
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b1)         begin n_fail++; $display("FAIL idle_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_first_post();
        logic [4:0]  ea [8];
        logic [31:0] ed [8];
        int k = 0;
        ea = '{5'd4, 5'd5, 5'd6, 5'd8, 5'd9, 5'd10, 5'd3, 5'd0};
        ed = '{32'h1000_0000, 32'd207360, 32'd2073600, 32'd1920, 32'd1080, 32'd0, 32'd0, 32'h3};
        clear_log();
        post(32'h1000_0000, 16'd1920, 16'd1080, 4'd0);
        while (!bus.av_write && k < 100) begin
            tick();
            k++;
        end
        n_checks++;
        if (k != 34) begin n_fail++; $display("FAIL first_write_latency: got %0d cycles want 34", k); end
        repeat (8) tick();
        n_checks++;
        if (log_a.size() != 8) begin n_fail++; $display("FAIL back_to_back: got %0d writes after 8 cycles want 8", log_a.size()); end
        for (int i = 0; i < 8 && i < log_a.size(); i++) begin
            n_checks++;
            if (log_a[i] !== ea[i] || log_d[i] !== ed[i]) begin
                n_fail++;
                $display("FAIL first_write%0d: got addr %0d data %0h want addr %0d data %0h", i, log_a[i], log_d[i], ea[i], ed[i]);
            end
        end
        n_checks += 3;
        if (running !== 1'b1)      begin n_fail++; $display("FAIL first_running: got %b want 1", running); end
        if (bus.av_write !== 1'b0) begin n_fail++; $display("FAIL first_idle_bus: got %b want 0", bus.av_write); end
        if (rel_cnt != 0)          begin n_fail++; $display("FAIL first_no_release: got %0d pulses want 0", rel_cnt); end
    endtask

    task automatic test_second_post();
        logic [4:0]  ea [9];
        logic [31:0] ed [9];
        ea = '{5'd2, 5'd11, 5'd12, 5'd13, 5'd15, 5'd16, 5'd17, 5'd3, 5'd2};
        ed = '{32'h1, 32'h1100_0000, 32'd30720, 32'd307200, 32'd640, 32'd480, 32'd2, 32'd1, 32'h1};
        clear_log();
        post(32'h1100_0000, 16'd640, 16'd480, 4'h2);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL slot_full_ready: got %b want 0", bus.in_ready); end
        bus.av_irq = 1'b1;
        wait_log(1, 20);
        bus.av_irq = 1'b0;
        tick();
        n_checks++;
        if (rel_cnt != 0) begin n_fail++; $display("FAIL first_ack_release: got %0d pulses want 0", rel_cnt); end
        wait_log(8, 200);
        repeat (4) tick();
        n_checks++;
        if (log_a.size() != 8) begin n_fail++; $display("FAIL no_second_go: got %0d writes want 8", log_a.size()); end
        bus.av_irq = 1'b1;
        wait_log(9, 20);
        bus.av_irq = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 9 && i < log_a.size(); i++) begin
            n_checks++;
            if (log_a[i] !== ea[i] || log_d[i] !== ed[i]) begin
                n_fail++;
                $display("FAIL second_write%0d: got addr %0d data %0h want addr %0d data %0h", i, log_a[i], log_d[i], ea[i], ed[i]);
            end
        end
        n_checks += 2;
        if (rel_cnt != 1)               begin n_fail++; $display("FAIL release_count: got %0d want 1", rel_cnt); end
        if (rel_last !== 32'h1000_0000) begin n_fail++; $display("FAIL release_base: got %0h want 10000000", rel_last); end
    endtask

    task automatic test_stall();
        logic [4:0]  ea [7];
        logic [31:0] ed [7];
        ea = '{5'd4, 5'd5, 5'd6, 5'd8, 5'd9, 5'd10, 5'd3};
        ed = '{32'h1200_0000, 32'd100, 32'd1000, 32'd100, 32'd10, 32'd0, 32'd0};
        clear_log();
        stall_seen = 0; stall_bad = 0; stall_left = 5;
        post(32'h1200_0000, 16'd100, 16'd10, 4'd0);
        wait_log(7, 300);
        repeat (3) tick();
        n_checks += 3;
        if (stall_seen != 5)   begin n_fail++; $display("FAIL stall_cycles: got %0d want 5", stall_seen); end
        if (stall_bad != 0)    begin n_fail++; $display("FAIL stall_data_stable: got %0d bad cycles want 0", stall_bad); end
        if (log_a.size() != 7) begin n_fail++; $display("FAIL stall_write_count: got %0d want 7", log_a.size()); end
        for (int i = 0; i < 7 && i < log_a.size(); i++) begin
            n_checks++;
            if (log_a[i] !== ea[i] || log_d[i] !== ed[i]) begin
                n_fail++;
                $display("FAIL stall_write%0d: got addr %0d data %0h want addr %0d data %0h", i, log_a[i], log_d[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_release_and_repeat();
        int r0 = rel_cnt;
        clear_log();
        bus.av_irq = 1'b1;
        wait_log(1, 20);
        bus.av_irq = 1'b0;
        repeat (2) tick();
        n_checks += 2;
        if (rel_cnt != r0 + 1)          begin n_fail++; $display("FAIL stall_release_count: got %0d want %0d", rel_cnt, r0 + 1); end
        if (rel_last !== 32'h1100_0000) begin n_fail++; $display("FAIL stall_release_base: got %0h want 11000000", rel_last); end
        bus.av_irq = 1'b1;
        wait_log(2, 20);
        bus.av_irq = 1'b0;
        repeat (3) tick();
        n_checks += 3;
        if (log_a.size() != 2)                 begin n_fail++; $display("FAIL repeat_write_count: got %0d want 2", log_a.size()); end
        else if (log_a[1] !== 5'd2 || log_d[1] !== 32'h1)
                                               begin n_fail++; $display("FAIL repeat_ack: got addr %0d data %0h want addr 2 data 1", log_a[1], log_d[1]); end
        if (rel_cnt != r0 + 1)                 begin n_fail++; $display("FAIL repeat_no_release: got %0d want %0d", rel_cnt, r0 + 1); end
`ifdef ALT_VFR_SCHED_STATS_EN
        n_checks += 2;
        if (frames_repeated !== 32'd2) begin n_fail++; $display("FAIL frames_repeated: got %0d want 2", frames_repeated); end
        if (frames_shown !== 32'd3)    begin n_fail++; $display("FAIL frames_shown: got %0d want 3", frames_shown); end
`endif
    endtask

    task automatic test_full_slot();
        logic [4:0]  ea [7];
        logic [31:0] ed [7];
        int t = 0;
        ea = '{5'd11, 5'd12, 5'd13, 5'd15, 5'd16, 5'd17, 5'd3};
        ed = '{32'h1300_0000, 32'd1, 32'd3, 32'd3, 32'd1, 32'd1, 32'd1};
        clear_log();
        post(32'h1300_0000, 16'd3, 16'd1, 4'd1);
        bus.in_valid = 1'b1; bus.in_base = 32'h1400_0000; bus.in_width = 16'd16; bus.in_height = 16'd16; bus.in_interlaced = 4'd0;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL held_post_ready0: got %b want 0", bus.in_ready); end
        repeat (10) tick();
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL held_post_ready_calc: got %b want 0", bus.in_ready); end
        while (!bus.in_ready && t < 200) begin
            tick();
            t++;
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL held_post_accept: got %b want 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if (log_a.size() != 7) begin n_fail++; $display("FAIL small_write_count: got %0d want 7", log_a.size()); end
        for (int i = 0; i < 7 && i < log_a.size(); i++) begin
            n_checks++;
            if (log_a[i] !== ea[i] || log_d[i] !== ed[i]) begin
                n_fail++;
                $display("FAIL small_write%0d: got addr %0d data %0h want addr %0d data %0h", i, log_a[i], log_d[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0]  ea [8];
        logic [31:0] ed [8];
        int r0 = rel_cnt;
        ea = '{5'd4, 5'd5, 5'd6, 5'd8, 5'd9, 5'd10, 5'd3, 5'd0};
        ed = '{32'h1500_0000, 32'd4, 32'd40, 32'd20, 32'd2, 32'd0, 32'd0, 32'h3};
        clear_log();
        bus.av_irq = 1'b1;
        wait_log(1, 20);
        bus.av_irq = 1'b0;
        wait_log(3, 100);
        n_checks += 3;
        if (rel_last !== 32'h1200_0000) begin n_fail++; $display("FAIL mid_release_base: got %0h want 12000000", rel_last); end
        if (log_a.size() >= 3 && (log_a[1] !== 5'd4 || log_d[1] !== 32'h1400_0000))
                                        begin n_fail++; $display("FAIL mid_base_write: got addr %0d data %0h want addr 4 data 14000000", log_a[1], log_d[1]); end
        if (log_a.size() >= 3 && (log_a[2] !== 5'd5 || log_d[2] !== 32'd26))
                                        begin n_fail++; $display("FAIL mid_words_ceil: got addr %0d data %0d want addr 5 data 26", log_a[2], log_d[2]); end
        r0 = rel_cnt;
        reset = 1'b1;
        tick();
        n_checks += 3;
        if (bus.av_write !== 1'b0) begin n_fail++; $display("FAIL mid_reset_write: got %b want 0", bus.av_write); end
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready: got %b want 0", bus.in_ready); end
        if (running !== 1'b0)      begin n_fail++; $display("FAIL mid_reset_running: got %b want 0", running); end
        tick();
        reset = 1'b0;
        tick();
        clear_log();
        post(32'h1500_0000, 16'd20, 16'd2, 4'd0);
        wait_log(8, 200);
        repeat (3) tick();
        for (int i = 0; i < 8 && i < log_a.size(); i++) begin
            n_checks++;
            if (log_a[i] !== ea[i] || log_d[i] !== ed[i]) begin
                n_fail++;
                $display("FAIL restart_write%0d: got addr %0d data %0h want addr %0d data %0h", i, log_a[i], log_d[i], ea[i], ed[i]);
            end
        end
        n_checks += 2;
        if (running !== 1'b1) begin n_fail++; $display("FAIL restart_running: got %b want 1", running); end
        if (rel_cnt != r0)    begin n_fail++; $display("FAIL restart_stale_release: got %0d want %0d", rel_cnt, r0); end
        enable = 1'b0;
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL disabled_ready: got %b want 0", bus.in_ready); end
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_first_post();
        test_second_post();
        test_stall();
        test_release_and_repeat();
        test_full_slot();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
